ctrl16b_seq: RTL
================

# ctrl16b_seq

Multi-cycle control sequencer for the 16-bit MAS core. It fetches instructions over a request/acknowledge handshake, holds each one in an instruction register for the decoder, and steps it through DECODE, EXEC, MEM and WB. It gates register-file and data-memory writes, captures load data, and owns the program counter, including JMP and CBZ redirection.

## Interface
- PCW, 8: program counter and instruction-address width.
- RST_PC, 0: program counter value after reset.

- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- run  in  1  level: start or continue executing; sampled in IDLE and WB.
- imem_addr  out  PCW  current PC.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  16  fetched instruction.
- instr  out  16  instruction register, drives the decoder.
- selType, selOp  in  2 each  decoder operation select; {selType,selOp}==4'he identifies CBZ.
- msel, memwen, rfen, jsel  in  1 each  decoder controls (LD, ST, register write, JMP).
- c  in  8  decoder immediate, used as jump/branch target.
- zero  in  1  datapath zero flag of the CBZ test operand.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write strobe (ST).
- dmem_ack  in  1  data access complete; dmem_rdata valid this cycle for LD.
- dmem_rdata  in  16  load data.
- mdr  out  16  memory data register (captured load data).
- rf_we  out  1  register-file write enable, one-cycle pulse.
- busy  out  1  state != IDLE.
- state  out  3  current state (debug).
- dvdd, dgnd  inout  1 each  module digital supply and ground.

## Operation
State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Encodings 6 and 7 go to IDLE.

- **IDLE:** all strobes low. Go to FETCH if run=1.
- **FETCH:** imem_req=1, imem_addr=pc.
  - On a cycle with imem_ack=1: instr <= imem_rdata, go to DECODE.
  - Otherwise stay; req stays high.
- **DECODE:** one cycle for decoder and register-file read settling. Go to EXEC.
- **EXEC:** one cycle for the ALU. If msel|memwen, go to MEM; else go to WB.
- **MEM:** dmem_req=1, dmem_we=memwen.
  - On dmem_ack=1: if msel, mdr <= dmem_rdata. Go to WB.
  - Otherwise stay.
- **WB:** rf_we=rfen for this one cycle. PC update:
  - jsel: pc <= c.
  - CBZ and zero=1: pc <= c.
  - Otherwise: pc <= pc+1.
  - Next state: FETCH if run=1, else IDLE.
- Target c is zero-extended, or truncated to its low PCW bits, to PCW bits.
- pc+1 wraps modulo 2^PCW (all-ones goes to 0).
- rf_we, dmem_req and dmem_we are never high outside WB and MEM respectively.
- ST, CBZ and JMP never pulse rf_we (rfen=0 from the decoder).
- instr is stable from DECODE through WB, so the decoder inputs may be used combinationally.
- run=0 mid-instruction: the instruction completes through WB, then the block parks in IDLE.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Reset (asynchronous, any state): state=IDLE, pc=RST_PC, instr=0, mdr=0. Every strobe output drops immediately, including an in-flight imem_req or dmem_req.

## Timing
- Strobes (imem_req, dmem_req, dmem_we, rf_we, busy) are decoded from the state register only. They have no combinational path from ack inputs.
- Ack may arrive in the first req cycle. Req deasserts the cycle after the ack edge.
- Zero-wait latency: non-memory instruction 4 cycles (FETCH, DECODE, EXEC, WB); LD/ST 5 cycles. Each wait cycle on an ack adds one.
- pc, instr and mdr update only at the listed edges.
- zero is sampled at the WB edge.

## Test plan
- Reset then run=1, imem_ack always 1, ADC instruction at pc 0:
  - state sequence 1,2,3,5,1;
  - rf_we high exactly in cycle 4;
  - pc becomes 1.
- ST with dmem_ack delayed 3 cycles:
  - dmem_req and dmem_we high for 4 cycles;
  - rf_we stays 0;
  - total 8 cycles;
  - pc increments.
- LD with dmem_rdata=16'hBEEF: mdr=16'hBEEF at WB, and rf_we pulses.
- Branches:
  - JMP with c=8'h42: pc=8'h42, rf_we=0.
  - CBZ with zero=1: pc=c.
  - CBZ with zero=0: pc=pc+1.
  - pc=8'hFF with a non-jump instruction: pc wraps to 0.
- run dropped during EXEC: the instruction completes and the block goes to IDLE with busy=0 and no further imem_req.
- rstn asserted during MEM with dmem_req high: dmem_req drops asynchronously, pc=RST_PC, state=0.

Source files
------------

// File: rtl/ctrl16b_seq_if.sv
// ctrl16b_seq_if: instruction-fetch and data-memory handshake bundle of the MAS sequencer.
// The sequencer is the master: it drives requests and the fetch address.
// The memories are the slave: they answer with an ack and read data.
interface ctrl16b_seq_if #(
    parameter int PCW = 8
);
    logic [PCW-1:0] imem_addr;
    logic           imem_req;
    logic           imem_ack;
    logic [15:0]    imem_rdata;
    logic           dmem_req;
    logic           dmem_we;
    logic           dmem_ack;
    logic [15:0]    dmem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/ctrl16b_seq.sv
// ctrl16b_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 16-bit MAS core.
// It owns the program counter, the instruction register and the memory data register.
// All strobes are decoded from the state register, so acks never reach them combinationally.
module ctrl16b_seq #(
    parameter int PCW    = 8,
    parameter int RST_PC = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    ctrl16b_seq_if.master bus,
    output logic [15:0]   instr,
    input  logic [1:0]    selType,
    input  logic [1:0]    selOp,
    input  logic          msel,
    input  logic          memwen,
    input  logic          rfen,
    input  logic          jsel,
    input  logic [7:0]    c,
    input  logic          zero,
    output logic [15:0]   mdr,
    output logic          rf_we,
    output logic          busy,
    output logic [2:0]    state,
    inout  wire           dvdd,
    inout  wire           dgnd
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [PCW-1:0] rst_pc_val = PCW'(RST_PC);

    state_t         cur_state;
    state_t         next_state;
    logic [PCW-1:0] pc;
    logic [PCW-1:0] target_pc;
    logic [PCW+7:0] c_wide;
    logic           is_cbz;
    logic           take_branch;
    logic           unused_bits;

    // Jump target: zero-extend c, then keep only the low PCW bits.
    assign c_wide      = {{PCW{1'b0}}, c};
    assign target_pc   = c_wide[PCW-1:0];
    assign is_cbz      = ({selType, selOp} == 4'he);
    assign take_branch = jsel | (is_cbz & zero);

    // Supply pins and the target bits above PCW carry no logic.
    assign unused_bits = ^{dvdd, dgnd, c_wide[PCW+7:PCW]};

    assign bus.imem_addr = pc;
    assign state         = cur_state;

    // State register, cleared asynchronously so every strobe drops at once on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic; the unused encodings 6 and 7 fall back to IDLE.
    always_comb begin
        next_state = IDLE;
        case (cur_state)
            IDLE:    next_state = run ? FETCH : IDLE;
            FETCH:   next_state = bus.imem_ack ? DECODE : FETCH;
            DECODE:  next_state = EXEC;
            EXEC:    next_state = (msel | memwen) ? MEM : WB;
            MEM:     next_state = bus.dmem_ack ? WB : MEM;
            WB:      next_state = run ? FETCH : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes decoded from the current state and the stable decoder controls only.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        rf_we        = 1'b0;
        busy         = (cur_state != IDLE);
        case (cur_state)
            FETCH: bus.imem_req = 1'b1;
            MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = memwen;
            end
            WB:      rf_we = rfen;
            default: ;
        endcase
    end

    // PC, instruction and load-data registers; each updates only at its own handshake or WB edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc    <= rst_pc_val;
            instr <= '0;
            mdr   <= '0;
        end else begin
            case (cur_state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        instr <= bus.imem_rdata;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack && msel) begin
                        mdr <= bus.dmem_rdata;
                    end
                end
                WB: begin
                    if (take_branch) begin
                        pc <= target_pc;
                    end else begin
                        pc <= pc + PCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
